// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 4x16 register file: shares the single write port
// between ALU and load paths and tracks pending writes per register.
module rf_wb_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREG  = 4,
   parameter int CNTW  = 2,
   localparam int SELW = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   input  logic [SELW-1:0]  alu_sel,
   input  logic [WIDTH-1:0] alu_data,
   output logic             alu_ready,
   input  logic             mem_valid,
   input  logic [SELW-1:0]  mem_sel,
   input  logic [WIDTH-1:0] mem_data,
   output logic             mem_ready,
   input  logic             claim_valid,
   input  logic [SELW-1:0]  claim_sel,
   output logic             claim_ready,
   input  logic             rd_en1,
   input  logic [SELW-1:0]  rd_sel1,
   input  logic             rd_en2,
   input  logic [SELW-1:0]  rd_sel2,
   output logic             rd_stall,
   output logic [WIDTH-1:0] rf_in,
   output logic [SELW-1:0]  rf_inSel,
   output logic             rf_inEn,
   output logic [NREG-1:0]  busy_mask,
   output logic             wb_err
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   logic                       rr_pri;
   logic                       gnt_alu, gnt_mem, conflict;
   logic [NREG-1:0][CNTW-1:0]  cnt;
   logic [NREG-1:0]            inc_vec, dec_vec, err_vec;
   logic                       retire_claim;

   // rr_pri=0 favours mem on conflict, 1 favours alu
   always_comb begin
      conflict = alu_valid & mem_valid;
      gnt_mem  = mem_valid & (~alu_valid | ~rr_pri);
      gnt_alu  = alu_valid & (~mem_valid | rr_pri);
   end

   assign alu_ready = gnt_alu;
   assign mem_ready = gnt_mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_pri   <= 1'b0;
         rf_in    <= '0;
         rf_inSel <= '0;
         rf_inEn  <= 1'b0;
      end else begin
         if (conflict) rr_pri <= ~rr_pri;
         rf_inEn <= gnt_alu | gnt_mem;
         if (gnt_alu) begin
            rf_in    <= alu_data;
            rf_inSel <= alu_sel;
         end else if (gnt_mem) begin
            rf_in    <= mem_data;
            rf_inSel <= mem_sel;
         end
      end
   end

   // a write retiring into the claimed register frees a slot the same cycle
   assign retire_claim = rf_inEn & (rf_inSel == claim_sel);
   assign claim_ready  = (cnt[claim_sel] != CNT_MAX) | retire_claim;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         inc_vec[r]   = claim_valid & claim_ready & (claim_sel == SELW'(r));
         dec_vec[r]   = rf_inEn & (rf_inSel == SELW'(r));
         err_vec[r]   = dec_vec[r] & ~inc_vec[r] & (cnt[r] == '0);
         busy_mask[r] = (cnt[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         wb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (inc_vec[r] & ~dec_vec[r])
               cnt[r] <= cnt[r] + CNTW'(1);
            else if (dec_vec[r] & ~inc_vec[r] & (cnt[r] != '0))
               cnt[r] <= cnt[r] - CNTW'(1);
         end
         if (|err_vec) wb_err <= 1'b1;
      end
   end

   assign rd_stall = (rd_en1 & busy_mask[rd_sel1]) | (rd_en2 & busy_mask[rd_sel2]);

endmodule
